// File: rtl/burst_mode_ctrl.sv
// burst_mode_ctrl: CellularRAM sequencer (power-up wait, BCR write, burst read/write strobes).
// Define BURST_WAIT_EN to honour MemWait: LAT exits and XFER beats wait for MemWait low.
module burst_mode_ctrl #(
  parameter int INIT_CYCLES = 15000,
  parameter int CFG_CYCLES  = 4,
  parameter int LAT_CYCLES  = 3,
  parameter int BURST_LEN   = 16,
  parameter int REC_CYCLES  = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req,
  input  logic        ReqWrite,
  input  logic [19:0] ReqAddr,
  input  logic        MemWait,
  output logic        Ready,
  output logic        Busy,
  output logic        RdValid,
  output logic        WrNext,
  output logic        Done,
  output logic [2:0]  Mode,
  output logic [19:0] AddrOut,
  output logic        MemCE_n,
  output logic        MemOE_n,
  output logic        MemWE_n,
  output logic        MemADV_n,
  output logic        MemLB_n,
  output logic        MemUB_n,
  output logic        MemCRE,
  output logic        MemClkEn
);
  typedef enum logic [2:0] {S_INIT, S_CFG, S_IDLE, S_ADDR, S_LAT, S_XFER, S_REC} state_t;
  typedef struct packed {
    logic       ready, busy, rdv, wrn, done;
    logic [2:0] mode;
    logic       ce_n, oe_n, we_n, adv_n, lb_n, ub_n, cre, clken;
  } out_t;
  localparam out_t OUT_RST = '{ready: 1'b0, busy: 1'b0, rdv: 1'b0, wrn: 1'b0, done: 1'b0,
                               mode: 3'b000, ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, adv_n: 1'b1,
                               lb_n: 1'b1, ub_n: 1'b1, cre: 1'b0, clken: 1'b0};
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  beat_q, beat_d;
  logic        wr_q, wr_d, cfg_q, cfg_d, stall;
  logic [19:0] addr_q, addr_d;
  out_t        o_q, o_d;
`ifdef BURST_WAIT_EN
  assign stall = MemWait;
`else
  assign stall = MemWait & 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    wr_d    = wr_q;
    cfg_d   = cfg_q;
    addr_d  = addr_q;
    case (state_q)
      S_INIT: if (cnt_q == '0) begin
        state_d = S_CFG;
        cnt_d   = 16'(CFG_CYCLES - 1);
      end else cnt_d = cnt_q - 16'd1;
      S_CFG: if (cnt_q == '0) begin
        state_d = S_REC;
        cnt_d   = 16'(REC_CYCLES - 1);
        cfg_d   = 1'b1;
      end else cnt_d = cnt_q - 16'd1;
      S_IDLE: if (Req) begin
        state_d = S_ADDR;
        wr_d    = ReqWrite;
        addr_d  = ReqAddr;
      end
      S_ADDR: begin
        state_d = S_LAT;
        cnt_d   = 16'(LAT_CYCLES - 1);
      end
      S_LAT: if (cnt_q != '0) cnt_d = cnt_q - 16'd1;
      else if (!stall) begin
        state_d = S_XFER;
        beat_d  = '0;
      end
      // A beat is counted at the end of each cycle whose valid strobe was driven
      S_XFER: if (o_q.rdv | o_q.wrn) begin
        if (beat_q == 8'(BURST_LEN - 1)) begin
          state_d = S_REC;
          cnt_d   = 16'(REC_CYCLES - 1);
        end else beat_d = beat_q + 8'd1;
      end
      S_REC: if (cnt_q == '0) state_d = S_IDLE;
      else cnt_d = cnt_q - 16'd1;
      default: state_d = S_INIT;
    endcase
  end
  always_comb begin
    o_d       = OUT_RST;
    o_d.ready = (state_d == S_IDLE) && cfg_d;
    o_d.busy  = state_d inside {S_ADDR, S_LAT, S_XFER};
    o_d.done  = (state_d == S_REC) && (state_q == S_XFER);
    case (state_d)
      S_CFG: begin
        o_d.mode  = 3'b010;
        o_d.cre   = 1'b1;
        o_d.ce_n  = 1'b0;
        o_d.we_n  = 1'b0;
        o_d.adv_n = (state_q == S_CFG);
      end
      S_ADDR: begin
        o_d.mode  = 3'b100;
        o_d.ce_n  = 1'b0;
        o_d.adv_n = 1'b0;
        o_d.clken = 1'b1;
        o_d.lb_n  = 1'b0;
        o_d.ub_n  = 1'b0;
        o_d.we_n  = !wr_d;
      end
      S_LAT, S_XFER: begin
        o_d.mode  = wr_d ? 3'b011 : 3'b001;
        o_d.ce_n  = 1'b0;
        o_d.oe_n  = wr_d;
        o_d.clken = 1'b1;
        o_d.lb_n  = 1'b0;
        o_d.ub_n  = 1'b0;
        o_d.rdv   = (state_d == S_XFER) && !stall && !wr_d;
        o_d.wrn   = (state_d == S_XFER) && !stall && wr_d;
      end
      default: ;
    endcase
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_INIT;
      cnt_q   <= 16'(INIT_CYCLES);
      beat_q  <= '0;
      wr_q    <= 1'b0;
      cfg_q   <= 1'b0;
      addr_q  <= '0;
      o_q     <= OUT_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      wr_q    <= wr_d;
      cfg_q   <= cfg_d;
      addr_q  <= addr_d;
      o_q     <= o_d;
    end
  end
  assign {Ready, Busy, RdValid, WrNext, Done, Mode, MemCE_n, MemOE_n, MemWE_n,
          MemADV_n, MemLB_n, MemUB_n, MemCRE, MemClkEn} = o_q;
  assign AddrOut = addr_q;
endmodule

// File: tb/tb_burst_mode_ctrl.sv
// tb_burst_mode_ctrl: timeline reference model plus directed literal checks and random traffic.
module tb_burst_mode_ctrl;
  localparam int INIT = 10, CFG = 4, LAT = 3, BL = 16, REC = 1;
  localparam int IDLE_AT = INIT + CFG + REC + 1;
  localparam int END = LAT + BL + REC + 2;
`ifdef BURST_WAIT_EN
  localparam int WAIT_DLY = 3;
`else
  localparam int WAIT_DLY = 0;
`endif
  localparam logic [35:0] RST_VEC = {5'b0, 3'b000, 20'h0, 8'hFC};
  logic clk = 0, rst = 0, req = 0, rw = 0, mw = 0;
  logic [19:0] addr = '0;
  logic Ready, Busy, RdValid, WrNext, Done, MemCE_n, MemOE_n, MemWE_n, MemADV_n;
  logic MemLB_n, MemUB_n, MemCRE, MemClkEn;
  logic [2:0] Mode;
  logic [19:0] AddrOut;
  int vec = 0, mis = 0;
  bit en = 0;
  burst_mode_ctrl #(.INIT_CYCLES(INIT), .CFG_CYCLES(CFG), .LAT_CYCLES(LAT),
                    .BURST_LEN(BL), .REC_CYCLES(REC)) dut (
    .Clk(clk), .Reset(rst), .Req(req), .ReqWrite(rw), .ReqAddr(addr), .MemWait(mw),
    .Ready(Ready), .Busy(Busy), .RdValid(RdValid), .WrNext(WrNext), .Done(Done),
    .Mode(Mode), .AddrOut(AddrOut), .MemCE_n(MemCE_n), .MemOE_n(MemOE_n),
    .MemWE_n(MemWE_n), .MemADV_n(MemADV_n), .MemLB_n(MemLB_n), .MemUB_n(MemUB_n),
    .MemCRE(MemCRE), .MemClkEn(MemClkEn));
  always #5 clk = ~clk;
  // ic: cycles since reset release (saturating); pos: position in the current burst timeline
  int ic, pos;
  bit stl, mwr;
  logic [19:0] maddr;
  always @(posedge clk or posedge rst) begin : model
    bit w;
    w = 0;
`ifdef BURST_WAIT_EN
    w = mw;
`endif
    if (rst) begin
      ic = 0; pos = 0; stl = 0; mwr = 0; maddr = '0;
    end else begin
      if (pos == 0) begin
        if (ic >= IDLE_AT && req) begin pos = 1; mwr = rw; maddr = addr; end
      end else if (w && pos + 1 >= LAT + 2 && pos + 1 <= LAT + BL + 1) stl = 1;
      else begin
        stl = 0;
        pos = (pos + 1 == END) ? 0 : pos + 1;
      end
      if (ic < IDLE_AT) ic++;
    end
  end
  function automatic logic [35:0] expv();
    logic rdy, bsy, rv, wn, dn, ce, oe, we, adv, lb, cre, ck;
    logic [2:0] md;
    {rdy, bsy, rv, wn, dn, md} = '0;
    {ce, oe, we, adv, lb, cre, ck} = 7'b1111100;
    if (ic >= INIT + 1 && ic <= INIT + CFG) begin
      md = 3'b010; cre = 1; ce = 0; we = 0; adv = (ic != INIT + 1);
    end
    rdy = (ic >= IDLE_AT && pos == 0);
    if (pos == 1) begin
      bsy = 1; md = 3'b100; ce = 0; adv = 0; ck = 1; lb = 0; we = !mwr;
    end else if (pos >= 2 && pos <= LAT + BL + 1) begin
      bsy = 1; md = mwr ? 3'b011 : 3'b001; ce = 0; oe = mwr; ck = 1; lb = 0;
      rv = pos >= LAT + 2 && !stl && !mwr;
      wn = pos >= LAT + 2 && !stl && mwr;
    end
    dn = (pos == LAT + BL + 2);
    return {rdy, bsy, rv, wn, dn, md, maddr, ce, oe, we, adv, lb, lb, cre, ck};
  endfunction
  function automatic logic [35:0] actv();
    return {Ready, Busy, RdValid, WrNext, Done, Mode, AddrOut, MemCE_n, MemOE_n, MemWE_n,
            MemADV_n, MemLB_n, MemUB_n, MemCRE, MemClkEn};
  endfunction
  task automatic chk(string nm, logic [35:0] act, logic [35:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) if (en) chk("cycle", actv(), expv());
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic init_seq(string tag);
    int we_lo = 0;
    logic cre11 = 0, adv11 = 1, rdy15 = 0, rdy16 = 0;
    logic [2:0] m11 = '0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      we_lo += int'(!MemWE_n);
      if (k == 11) begin cre11 = MemCRE; m11 = Mode; adv11 = MemADV_n; end
      if (k == 15) rdy15 = Ready;
      if (k == 16) rdy16 = Ready;
    end
    chk({tag, "_cfg_cre"}, 36'(cre11), 36'd1);
    chk({tag, "_cfg_mode"}, 36'(m11), 36'd2);
    chk({tag, "_cfg_adv"}, 36'(adv11), 36'd0);
    chk({tag, "_cfg_we_width"}, 36'(we_lo), 36'd4);
    chk({tag, "_ready15"}, 36'(rdy15), 36'd0);
    chk({tag, "_ready16"}, 36'(rdy16), 36'd1);
  endtask
  int nbeat, first_b, done_at, rdy_at, adv_lo, we_lo, oe_lo;
  logic [2:0] m1, m2, m23;
  logic [19:0] a1;
  task automatic run_burst(bit wr, logic [19:0] a, int hold_from, int mw_at, int n);
    nbeat = 0; first_b = -1; done_at = -1; rdy_at = -1; adv_lo = 0; we_lo = 0; oe_lo = 0;
    req = 1; rw = wr; addr = a;
    tick();
    req = 0;
    for (int j = 1; j <= n; j++) begin
      if (j == 1) begin m1 = Mode; a1 = AddrOut; end
      if (j == 2) m2 = Mode;
      if (j == 23) m23 = Mode;
      if (RdValid | WrNext) begin nbeat++; if (first_b < 0) first_b = j; end
      if (Done && done_at < 0) done_at = j;
      if (Ready && rdy_at < 0) rdy_at = j;
      adv_lo += int'(!MemADV_n); we_lo += int'(!MemWE_n); oe_lo += int'(!MemOE_n);
      if (hold_from > 0) req = (j >= hold_from && j < 23);
      mw = (mw_at > 0 && j >= mw_at && j < mw_at + 3);
      tick();
    end
    req = 0; mw = 0;
  endtask
  initial begin
    #2 rst = 1;
    en = 1;
    #1 chk("reset_vec", actv(), RST_VEC);
    tick(); tick();
    rst = 0;
    init_seq("pwrup");
    run_burst(0, 20'h0003F, 0, 0, 23);
    chk("rd_addr", 36'(a1), 36'h3F);
    chk("rd_mode_addr", 36'(m1), 36'd4);
    chk("rd_mode_lat", 36'(m2), 36'd1);
    chk("rd_adv_low", 36'(adv_lo), 36'd1);
    chk("rd_first_beat", 36'(first_b), 36'd5);
    chk("rd_beats", 36'(nbeat), 36'd16);
    chk("rd_done", 36'(done_at), 36'd21);
    chk("rd_ready", 36'(rdy_at), 36'd22);
    run_burst(1, 20'hABCDE, 0, 0, 23);
    chk("wr_mode", 36'(m2), 36'd3);
    chk("wr_we_low", 36'(we_lo), 36'd1);
    chk("wr_oe_low", 36'(oe_lo), 36'd0);
    chk("wr_beats", 36'(nbeat), 36'd16);
    chk("wr_done", 36'(done_at), 36'd21);
    run_burst(0, 20'h12345, 0, 8, 26);
    chk("wait_beats", 36'(nbeat), 36'd16);
    chk("wait_done", 36'(done_at), 36'(21 + WAIT_DLY));
    run_burst(0, 20'h00100, 8, 0, 23);
    chk("hold_beats", 36'(nbeat), 36'd16);
    chk("hold_ready", 36'(rdy_at), 36'd22);
    chk("hold_new_addr", 36'(m23), 36'd4);
    repeat (25) tick();
    run_burst(1, 20'h0F0F0, 0, 0, 10);
    rst = 1;
    #1 chk("midburst_reset", actv(), RST_VEC);
    tick();
    rst = 0;
    init_seq("rerun");
    for (int i = 0; i < 1500; i++) begin
      req = ($urandom % 4) == 0;
      rw = 1'($urandom);
      addr = 20'($urandom);
      mw = ($urandom % 4) == 0;
      tick();
    end
    req = 0; mw = 0;
    repeat (30) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
